// File: rtl/seven_segment_scan_ctrl.sv
// Scan controller that time-multiplexes one BCD-to-7-segment decoder across
// NUM_DIGITS digits, with per-slot blanking and frame-aligned value commits.
module seven_segment_scan_ctrl #(
   parameter int   NUM_DIGITS         = 4,
   parameter int   REFRESH_DIV        = 50000,
   parameter int   BLANK_CYCLES       = 4,
   parameter logic DIGIT_ACTIVE       = 1'b0,
   parameter bit   LEADING_ZERO_BLANK = 1'b1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            enable,
   input  logic                            load_valid,
   output logic                            load_ready,
   input  logic [4*NUM_DIGITS-1:0]         load_data,
   output logic [3:0]                      bcd,
   output logic [NUM_DIGITS-1:0]           dig_en,
   output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
   output logic                            frame_done
);

   localparam int SLOT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W  = $clog2(NUM_DIGITS);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
   localparam logic [SLOT_W-1:0] SLOT_SHOW = SLOT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

   state_t                  state, state_nxt;
   logic [SLOT_W-1:0]       slot, slot_nxt;
   logic [IDX_W-1:0]        idx_nxt;
   logic [4*NUM_DIGITS-1:0] disp, disp_nxt, pending;
   logic                    pending_full;
   logic                    accept, commit;
   logic [3:0]              bcd_nxt;
   logic                    upper_zero;

   // load_ready mirrors ~pending_full, so accept and commit never coincide.
   assign accept   = load_valid & load_ready;
   assign commit   = pending_full & ((state == IDLE) | frame_done);
   assign disp_nxt = commit ? pending : disp;

   always_comb begin
      state_nxt = IDLE;
      slot_nxt  = '0;
      idx_nxt   = '0;
      if (enable) begin
         if (state == IDLE) begin
            state_nxt = BLANK;
         end else if (slot == SLOT_LAST) begin
            state_nxt = BLANK;
            idx_nxt   = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
         end else begin
            slot_nxt  = slot + 1'b1;
            idx_nxt   = digit_idx;
            state_nxt = (slot_nxt >= SLOT_SHOW) ? SHOW : BLANK;
         end
      end
   end

   // bcd is computed from the post-commit display so a new frame starts clean.
   always_comb begin
      bcd_nxt    = 4'hF;
      upper_zero = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i >= int'(idx_nxt) && disp_nxt[4*i +: 4] != 4'h0) upper_zero = 1'b0;
         if (i == int'(idx_nxt)) bcd_nxt = disp_nxt[4*i +: 4];
      end
      if (LEADING_ZERO_BLANK && idx_nxt != '0 && upper_zero) bcd_nxt = 4'hF;
      if (state_nxt == IDLE) bcd_nxt = 4'hF;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         slot         <= '0;
         digit_idx    <= '0;
         bcd          <= 4'hF;
         dig_en       <= {NUM_DIGITS{~DIGIT_ACTIVE}};
         frame_done   <= 1'b0;
         load_ready   <= 1'b1;
         disp         <= {NUM_DIGITS{4'hF}};
         pending      <= '0;
         pending_full <= 1'b0;
      end else begin
         state      <= state_nxt;
         slot       <= slot_nxt;
         digit_idx  <= idx_nxt;
         bcd        <= bcd_nxt;
         frame_done <= (state_nxt == SHOW) && (idx_nxt == IDX_LAST) && (slot_nxt == SLOT_LAST);
         for (int i = 0; i < NUM_DIGITS; i++)
            dig_en[i] <= (state_nxt == SHOW && idx_nxt == IDX_W'(i)) ? DIGIT_ACTIVE : ~DIGIT_ACTIVE;
         disp <= disp_nxt;
         if (accept) begin
            pending      <= load_data;
            pending_full <= 1'b1;
            load_ready   <= 1'b0;
         end else if (commit) begin
            pending_full <= 1'b0;
            load_ready   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Bench for seven_segment_scan_ctrl: directed scenarios then random traffic,
// every cycle compared against a frame-position reference model.
module tb_seven_segment_scan_ctrl;
   localparam int N = 4;
   localparam int R = 8;
   localparam int B = 2;
   localparam int FRAME = N * R;

   logic        clk = 1'b0;
   logic        rst, enable, load_valid;
   logic [15:0] load_data;
   logic        load_ready, frame_done;
   logic [3:0]  bcd;
   logic [3:0]  dig_en;
   logic [1:0]  digit_idx;

   int checks = 0;
   int errors = 0;

   // reference model: position within the frame (-1 when idle) and value registers
   int          m_pos;
   logic [15:0] m_disp, m_pend;
   bit          m_pfull, m_ready;

   seven_segment_scan_ctrl #(
      .NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B),
      .DIGIT_ACTIVE(1'b0), .LEADING_ZERO_BLANK(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .load_valid(load_valid),
      .load_ready(load_ready), .load_data(load_data), .bcd(bcd),
      .dig_en(dig_en), .digit_idx(digit_idx), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [3:0] exp_bcd(input int d);
      bit allz = 1'b1;
      logic [15:0] v = m_disp;
      for (int k = d; k < N; k++) if (v[4*k +: 4] != 4'h0) allz = 1'b0;
      if (d > 0 && allz) return 4'hF;
      return v[4*d +: 4];
   endfunction

   task automatic model_step();
      bit fd;
      if (rst) begin
         m_pos = -1; m_disp = 16'hFFFF; m_pfull = 1'b0; m_ready = 1'b1;
      end else begin
         fd = (m_pos >= 0) && (m_pos % FRAME == FRAME - 1);
         if (m_pfull && (m_pos < 0 || fd)) begin m_disp = m_pend; m_pfull = 1'b0; end
         else if (load_valid && m_ready) begin m_pend = load_data; m_pfull = 1'b1; end
         m_pos   = enable ? (m_pos + 1) % FRAME : -1;
         m_ready = !m_pfull;
      end
   endtask

   task automatic check_all();
      int d, s;
      if (m_pos < 0) begin
         chk("dig_en", 16'(dig_en), 16'hF);
         chk("bcd", 16'(bcd), 16'hF);
         chk("digit_idx", 16'(digit_idx), 16'd0);
         chk("frame_done", 16'(frame_done), 16'd0);
      end else begin
         d = m_pos / R;
         s = m_pos % R;
         chk("dig_en", 16'(dig_en), (s >= B) ? 16'(4'hF & ~(4'd1 << d)) : 16'hF);
         chk("bcd", 16'(bcd), 16'(exp_bcd(d)));
         chk("digit_idx", 16'(digit_idx), 16'(d));
         chk("frame_done", 16'(frame_done), 16'(d == N - 1 && s == R - 1));
      end
      chk("load_ready", 16'(load_ready), 16'(m_ready));
   endtask

   task automatic cyc(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         check_all();
      end
   endtask

   task automatic wait_pos(input int p);
      for (int k = 0; k < 2 * FRAME && m_pos != p; k++) cyc();
   endtask

   initial begin
      logic [15:0] rd;
      rst = 1'b1; enable = 1'b0; load_valid = 1'b0; load_data = '0;
      m_pos = -1; m_disp = 16'hFFFF; m_pend = '0; m_pfull = 1'b0; m_ready = 1'b1;

      // reset
      cyc(3);
      chk("rst_dig_en", 16'(dig_en), 16'hF);
      chk("rst_bcd", 16'(bcd), 16'hF);
      chk("rst_ready", 16'(load_ready), 16'd1);
      rst = 1'b0;
      cyc(2);

      // load while idle, then scan
      load_valid = 1'b1; load_data = 16'h1234;
      cyc();
      load_valid = 1'b0;
      cyc(2);
      enable = 1'b1;
      cyc();
      chk("first_slot_bcd", 16'(bcd), 16'h4);
      chk("first_slot_blank", 16'(dig_en), 16'hF);
      cyc(B);
      chk("first_slot_lit", 16'(dig_en), 16'hE);
      cyc(2 * FRAME + 5);

      // leading-zero blanking
      load_valid = 1'b1; load_data = 16'h0070;
      cyc();
      load_valid = 1'b0;
      cyc(2 * FRAME + 3);
      load_valid = 1'b1; load_data = 16'h0000;
      cyc();
      load_valid = 1'b0;
      cyc(2 * FRAME + 3);

      // mid-frame load defers to the frame boundary; held second load waits
      load_valid = 1'b1; load_data = 16'h1234;
      cyc();
      load_valid = 1'b0;
      cyc(2 * FRAME);
      wait_pos(10);
      load_valid = 1'b1; load_data = 16'h5678;
      cyc();
      chk("ready_low_after_load", 16'(load_ready), 16'd0);
      load_data = 16'h4321;
      cyc(2 * FRAME + 4);
      load_valid = 1'b0;
      cyc(FRAME);

      // enable drop mid-slot
      wait_pos(13);
      enable = 1'b0;
      cyc();
      chk("drop_dig_en", 16'(dig_en), 16'hF);
      chk("drop_idx", 16'(digit_idx), 16'd0);
      cyc(2);
      enable = 1'b1;
      cyc(FRAME);

      // reset with a load pending
      wait_pos(19);
      load_valid = 1'b1; load_data = 16'h9999;
      cyc();
      rst = 1'b1;
      cyc();
      chk("rst_mid_bcd", 16'(bcd), 16'hF);
      rst = 1'b0; load_valid = 1'b0;
      cyc(FRAME + 4);

      // random traffic
      for (int c = 0; c < 1500; c++) begin
         rst        = ($urandom_range(0, 199) == 0);
         enable     = ($urandom_range(0, 19) != 0);
         load_valid = ($urandom_range(0, 3) == 0);
         for (int k = 0; k < N; k++)
            rd[4*k +: 4] = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0;
         load_data = rd;
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
